// File: rtl/sparrow_writeback.sv
// Writeback stage: arbitrates ALU results against a small in-order load-response FIFO
// onto one register-file write port and tracks outstanding loads. Optional macro: SPARROW_WB_BYPASS_EN.
module sparrow_writeback #(
    parameter int LQ_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_alu_valid,
    output logic        o_alu_ready,
    input  logic [4:0]  i_alu_rd,
    input  logic [31:0] i_alu_data,
    input  logic        i_ld_valid,
    output logic        o_ld_ready,
    input  logic [4:0]  i_ld_rd,
    input  logic [31:0] i_ld_data,
    input  logic        i_ld_issue,
    input  logic [4:0]  i_ld_issue_rd,
    output logic        o_wr_en,
    output logic [4:0]  o_wr_addr,
    output logic [31:0] o_wr_data,
    output logic [31:0] o_busy
`ifdef SPARROW_WB_BYPASS_EN
    ,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic        o_fwd1_hit,
    output logic [31:0] o_fwd1_data,
    output logic        o_fwd2_hit,
    output logic [31:0] o_fwd2_data
`endif
);

    localparam int PW = $clog2(LQ_DEPTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid may not depend on ready, and ready depends only on registered state.

    logic [4:0]  lq_rd   [LQ_DEPTH];
    logic [31:0] lq_data [LQ_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;

    logic        lq_full, lq_empty;
    logic [4:0]  head_rd;
    logic [31:0] head_data;
    logic        alu_win, ld_win, win_any;
    logic [4:0]  win_rd;
    logic [31:0] win_data;
    logic        push;
    logic [31:0] set_mask, clr_mask, busy_next;

    // Extra wrap bit distinguishes full (same index, different lap) from empty.
    assign lq_empty  = (wr_ptr == rd_ptr);
    assign lq_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head_rd   = lq_rd[rd_ptr[PW-1:0]];
    assign head_data = lq_data[rd_ptr[PW-1:0]];

    assign o_ld_ready  = ~lq_full;
    assign o_alu_ready = ~lq_full;

    // A full queue blocks the ALU, so the head wins; otherwise ALU has priority over queued loads.
    assign alu_win  = i_alu_valid & ~lq_full;
    assign ld_win   = ~alu_win & ~lq_empty;
    assign win_any  = alu_win | ld_win;
    assign win_rd   = alu_win ? i_alu_rd   : head_rd;
    assign win_data = alu_win ? i_alu_data : head_data;
    assign push     = i_ld_valid & ~lq_full;

    assign set_mask  = (i_ld_issue && (i_ld_issue_rd != 5'd0)) ? (32'd1 << i_ld_issue_rd) : 32'd0;
    assign clr_mask  = (ld_win && (head_rd != 5'd0)) ? (32'd1 << head_rd) : 32'd0;
    assign busy_next = (o_busy & ~clr_mask) | set_mask;

    always_ff @(posedge i_clk) begin
        if (push) begin
            lq_rd[wr_ptr[PW-1:0]]   <= i_ld_rd;
            lq_data[wr_ptr[PW-1:0]] <= i_ld_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= 5'd0;
            o_wr_data <= 32'd0;
            o_busy    <= 32'd0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (ld_win) rd_ptr <= rd_ptr + 1'b1;
            o_wr_en <= win_any && (win_rd != 5'd0);
            // Address/data only move on a real write so they hold otherwise.
            if (win_any && (win_rd != 5'd0)) begin
                o_wr_addr <= win_rd;
                o_wr_data <= win_data;
            end
            o_busy <= busy_next;
        end
    end

`ifdef SPARROW_WB_BYPASS_EN
    assign o_fwd1_hit  = o_wr_en & (o_wr_addr == i_rs1_addr);
    assign o_fwd1_data = o_wr_data;
    assign o_fwd2_hit  = o_wr_en & (o_wr_addr == i_rs2_addr);
    assign o_fwd2_data = o_wr_data;
`endif

endmodule
